// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: instruction codes and special register IDs.
package y86_pkg;

    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRRMOVQ = 4'h2;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    localparam logic [3:0] RRSP  = 4'h4;
    localparam logic [3:0] RNONE = 4'hF;

    localparam int NREGS = 15;

endpackage

// File: rtl/wb_dst_decode.sv
// Maps (icode, cnd, rA, rB) to the write-back destinations dstE and dstM.
// Build option WB_CMOV_EN: when defined, icode 0x2 writes only if cnd=1.
module wb_dst_decode
    import y86_pkg::*;
(
    input  logic [3:0] icode,
    input  logic       cnd,
    input  logic [3:0] rA,
    input  logic [3:0] rB,
    output logic [3:0] dstE,
    output logic [3:0] dstM
);

`ifndef WB_CMOV_EN
    logic unused_cnd_s;
    assign unused_cnd_s = cnd;
`endif

    // dstE selection: rB for register-result ops, rsp for stack ops.
    always_comb begin
        dstE = RNONE;
        case (icode)
            IRRMOVQ: begin
`ifdef WB_CMOV_EN
                if (cnd) begin
                    dstE = rB;
                end else begin
                    dstE = RNONE;
                end
`else
                dstE = rB;
`endif
            end
            IIRMOVQ, IOPQ:                 dstE = rB;
            ICALL, IRET, IPUSHQ, IPOPQ:    dstE = RRSP;
            default:                       dstE = RNONE;
        endcase
    end

    // dstM selection: only loads from memory target rA.
    always_comb begin
        dstM = RNONE;
        case (icode)
            IMRMOVQ, IPOPQ: dstM = rA;
            default:        dstM = RNONE;
        endcase
    end

endmodule

// File: rtl/y86_writeback.sv
// SEQ Y86-64 write-back stage: 15 registered next-values of the register file.
// Build option WB_CMOV_EN enables conditional moves (see wb_dst_decode).
module y86_writeback
    import y86_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  icode,
    input  logic        cnd,
    input  logic [3:0]  rA,
    input  logic [3:0]  rB,
    input  logic [63:0] ValE,
    input  logic [63:0] ValM,
    input  logic [63:0] rax,
    input  logic [63:0] rcx,
    input  logic [63:0] rdx,
    input  logic [63:0] rbx,
    input  logic [63:0] rsp,
    input  logic [63:0] rbp,
    input  logic [63:0] rsi,
    input  logic [63:0] rdi,
    input  logic [63:0] r8,
    input  logic [63:0] r9,
    input  logic [63:0] r10,
    input  logic [63:0] r11,
    input  logic [63:0] r12,
    input  logic [63:0] r13,
    input  logic [63:0] r14,
    output logic [63:0] reg0,
    output logic [63:0] reg1,
    output logic [63:0] reg2,
    output logic [63:0] reg3,
    output logic [63:0] reg4,
    output logic [63:0] reg5,
    output logic [63:0] reg6,
    output logic [63:0] reg7,
    output logic [63:0] reg8,
    output logic [63:0] reg9,
    output logic [63:0] reg10,
    output logic [63:0] reg11,
    output logic [63:0] reg12,
    output logic [63:0] reg13,
    output logic [63:0] reg14
);

    logic [3:0]  dst_e_s;
    logic [3:0]  dst_m_s;
    logic [63:0] cur_s  [NREGS];
    logic [63:0] next_s [NREGS];
    logic [63:0] regs_r [NREGS];

    wb_dst_decode u_dst_decode (
        .icode (icode),
        .cnd   (cnd),
        .rA    (rA),
        .rB    (rB),
        .dstE  (dst_e_s),
        .dstM  (dst_m_s)
    );

    assign cur_s[0]  = rax;
    assign cur_s[1]  = rcx;
    assign cur_s[2]  = rdx;
    assign cur_s[3]  = rbx;
    assign cur_s[4]  = rsp;
    assign cur_s[5]  = rbp;
    assign cur_s[6]  = rsi;
    assign cur_s[7]  = rdi;
    assign cur_s[8]  = r8;
    assign cur_s[9]  = r9;
    assign cur_s[10] = r10;
    assign cur_s[11] = r11;
    assign cur_s[12] = r12;
    assign cur_s[13] = r13;
    assign cur_s[14] = r14;

    // Per-register next value; dstM wins over dstE, ID 0xF matches nothing.
    always_comb begin
        for (int i = 0; i < NREGS; i++) begin
            next_s[i] = cur_s[i];
            if (dst_m_s == 4'(i)) begin
                next_s[i] = ValM;
            end else if (dst_e_s == 4'(i)) begin
                next_s[i] = ValE;
            end else begin
                next_s[i] = cur_s[i];
            end
        end
    end

    // Output register bank with synchronous active-low clear.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NREGS; i++) begin
            if (!rst_n) begin
                regs_r[i] <= 64'd0;
            end else begin
                regs_r[i] <= next_s[i];
            end
        end
    end

    assign reg0  = regs_r[0];
    assign reg1  = regs_r[1];
    assign reg2  = regs_r[2];
    assign reg3  = regs_r[3];
    assign reg4  = regs_r[4];
    assign reg5  = regs_r[5];
    assign reg6  = regs_r[6];
    assign reg7  = regs_r[7];
    assign reg8  = regs_r[8];
    assign reg9  = regs_r[9];
    assign reg10 = regs_r[10];
    assign reg11 = regs_r[11];
    assign reg12 = regs_r[12];
    assign reg13 = regs_r[13];
    assign reg14 = regs_r[14];

endmodule

// File: tb/tb_y86_writeback.sv
// Directed self-checking bench for y86_writeback; register outputs are wired
// back to the current-value inputs as the processor would do.
module tb_y86_writeback;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  icode;
    logic        cnd;
    logic [3:0]  rA;
    logic [3:0]  rB;
    logic [63:0] ValE;
    logic [63:0] ValM;
    logic [63:0] dout [15];
    logic [63:0] exp_v [15];
    int          passed = 0;
    int          total  = 0;

    always #5 clk = ~clk;

    y86_writeback dut (
        .clk(clk), .rst_n(rst_n), .icode(icode), .cnd(cnd), .rA(rA), .rB(rB),
        .ValE(ValE), .ValM(ValM),
        .rax(dout[0]), .rcx(dout[1]), .rdx(dout[2]), .rbx(dout[3]),
        .rsp(dout[4]), .rbp(dout[5]), .rsi(dout[6]), .rdi(dout[7]),
        .r8(dout[8]), .r9(dout[9]), .r10(dout[10]), .r11(dout[11]),
        .r12(dout[12]), .r13(dout[13]), .r14(dout[14]),
        .reg0(dout[0]), .reg1(dout[1]), .reg2(dout[2]), .reg3(dout[3]),
        .reg4(dout[4]), .reg5(dout[5]), .reg6(dout[6]), .reg7(dout[7]),
        .reg8(dout[8]), .reg9(dout[9]), .reg10(dout[10]), .reg11(dout[11]),
        .reg12(dout[12]), .reg13(dout[13]), .reg14(dout[14])
    );

    task automatic drive(input logic [3:0] ic, input logic c, input logic [3:0] a,
                         input logic [3:0] b, input logic [63:0] e, input logic [63:0] m);
        @(negedge clk);
        icode = ic; cnd = c; rA = a; rB = b; ValE = e; ValM = m;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(4'h1, 1'b0, 4'hF, 4'hF, 64'd0, 64'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 15; i++) exp_v[i] = 64'd0;
        for (int i = 0; i < 15; i++) begin
            total++;
            if (dout[i] !== exp_v[i]) $display("FAIL reset reg%0d got %h want %h", i, dout[i], exp_v[i]);
            else passed++;
        end
    endtask

    task automatic test_irmovq_cmov();
        drive(4'h3, 1'b0, 4'hF, 4'h3, 64'd20, 64'd0);
        exp_v[3] = 64'd20;
        drive(4'h2, 1'b1, 4'h1, 4'h0, 64'd12, 64'd0);
        exp_v[0] = 64'd12;
        for (int i = 0; i < 15; i++) begin
            total++;
            if (dout[i] !== exp_v[i]) $display("FAIL irmovq_cmov reg%0d got %h want %h", i, dout[i], exp_v[i]);
            else passed++;
        end
        drive(4'h2, 1'b0, 4'h1, 4'h0, 64'd99, 64'd0);
`ifdef WB_CMOV_EN
        exp_v[0] = 64'd12;
`else
        exp_v[0] = 64'd99;
`endif
        for (int i = 0; i < 15; i++) begin
            total++;
            if (dout[i] !== exp_v[i]) $display("FAIL cmov_cnd0 reg%0d got %h want %h", i, dout[i], exp_v[i]);
            else passed++;
        end
    endtask

    task automatic test_mrmovq_opq();
        drive(4'h5, 1'b0, 4'h2, 4'hF, 64'd777, 64'd15);
        exp_v[2] = 64'd15;
        drive(4'h6, 1'b0, 4'h7, 4'h1, 64'd78, 64'd333);
        exp_v[1] = 64'd78;
        for (int i = 0; i < 15; i++) begin
            total++;
            if (dout[i] !== exp_v[i]) $display("FAIL mrmovq_opq reg%0d got %h want %h", i, dout[i], exp_v[i]);
            else passed++;
        end
    endtask

    task automatic test_call_ret();
        drive(4'h8, 1'b0, 4'hF, 4'hF, 64'd90, 64'd5);
        total++;
        if (dout[4] !== 64'd90) $display("FAIL call rsp got %h want %h", dout[4], 64'd90);
        else passed++;
        drive(4'h9, 1'b0, 4'hF, 4'hF, 64'd84, 64'd6);
        exp_v[4] = 64'd84;
        for (int i = 0; i < 15; i++) begin
            total++;
            if (dout[i] !== exp_v[i]) $display("FAIL call_ret reg%0d got %h want %h", i, dout[i], exp_v[i]);
            else passed++;
        end
    endtask

    task automatic test_popq();
        drive(4'hB, 1'b0, 4'h5, 4'hF, 64'd99, 64'd100);
        exp_v[4] = 64'd99;
        exp_v[5] = 64'd100;
        for (int i = 0; i < 15; i++) begin
            total++;
            if (dout[i] !== exp_v[i]) $display("FAIL popq reg%0d got %h want %h", i, dout[i], exp_v[i]);
            else passed++;
        end
        drive(4'hB, 1'b0, 4'h4, 4'hF, 64'd8, 64'd55);
        exp_v[4] = 64'd55;
        for (int i = 0; i < 15; i++) begin
            total++;
            if (dout[i] !== exp_v[i]) $display("FAIL popq_rsp reg%0d got %h want %h", i, dout[i], exp_v[i]);
            else passed++;
        end
    endtask

    task automatic test_no_write();
        drive(4'h0, 1'b1, 4'h1, 4'h2, 64'hAAAA, 64'hBBBB);
        drive(4'h1, 1'b1, 4'h1, 4'h2, 64'hAAAA, 64'hBBBB);
        drive(4'h4, 1'b1, 4'h1, 4'h2, 64'hAAAA, 64'hBBBB);
        drive(4'h7, 1'b1, 4'h1, 4'h2, 64'hAAAA, 64'hBBBB);
        drive(4'h3, 1'b1, 4'h1, 4'hF, 64'hAAAA, 64'hBBBB);
        drive(4'h6, 1'b1, 4'h1, 4'hF, 64'hAAAA, 64'hBBBB);
        drive(4'h5, 1'b1, 4'hF, 4'h2, 64'hAAAA, 64'hBBBB);
        drive(4'hC, 1'b1, 4'h1, 4'h2, 64'hAAAA, 64'hBBBB);
        drive(4'hF, 1'b1, 4'h1, 4'h2, 64'hAAAA, 64'hBBBB);
        for (int i = 0; i < 15; i++) begin
            total++;
            if (dout[i] !== exp_v[i]) $display("FAIL no_write reg%0d got %h want %h", i, dout[i], exp_v[i]);
            else passed++;
        end
    endtask

    task automatic test_r14_and_hold();
        drive(4'h3, 1'b0, 4'hF, 4'hE, 64'h1234_5678_9ABC_DEF0, 64'd0);
        exp_v[14] = 64'h1234_5678_9ABC_DEF0;
        total++;
        if (dout[14] !== exp_v[14]) $display("FAIL r14 got %h want %h", dout[14], exp_v[14]);
        else passed++;
        // Inputs changed mid-cycle must not show up before the next edge.
        @(negedge clk);
        icode = 4'h3; rB = 4'h6; ValE = 64'd7;
        #2;
        total++;
        if (dout[6] !== exp_v[6]) $display("FAIL hold_between_edges got %h want %h", dout[6], exp_v[6]);
        else passed++;
        @(posedge clk);
        #1;
        exp_v[6] = 64'd7;
        total++;
        if (dout[6] !== exp_v[6]) $display("FAIL back_to_back rsi got %h want %h", dout[6], exp_v[6]);
        else passed++;
    endtask

    task automatic test_reset_popq();
        rst_n = 1'b0;
        drive(4'hB, 1'b0, 4'h5, 4'hF, 64'd11, 64'd22);
        rst_n = 1'b1;
        for (int i = 0; i < 15; i++) exp_v[i] = 64'd0;
        for (int i = 0; i < 15; i++) begin
            total++;
            if (dout[i] !== exp_v[i]) $display("FAIL reset_popq reg%0d got %h want %h", i, dout[i], exp_v[i]);
            else passed++;
        end
    endtask

    initial begin
        rst_n = 1'b0; icode = 4'h1; cnd = 1'b0; rA = 4'hF; rB = 4'hF;
        ValE = 64'd0; ValM = 64'd0;
        test_reset();
        test_irmovq_cmov();
        test_mrmovq_opq();
        test_call_ret();
        test_popq();
        test_no_write();
        test_r14_and_hold();
        test_reset_popq();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
